// File: rtl/slc3_control_fsm.sv
// SLC-3 control unit: Moore FSM sequencing fetch, decode and execute.
// Every datapath control line is registered and depends only on the state being entered.
// Memory accesses (fetch read, LDR read, STR write) are held for MEM_WAIT cycles.
module slc3_control_fsm #(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    typedef enum logic [4:0] {
        S_HALTED, S_F1, S_F2, S_F3, S_DEC,
        S_ADD, S_AND, S_NOT,
        S_BR, S_BR_T, S_JMP,
        S_J1, S_J2,
        S_L1, S_L2, S_L3,
        S_S1, S_S2, S_S3,
        S_P1, S_P2
    } state_t;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_oe;
        logic       mem_we;
    } ctl_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

    state_t     state;
    logic [2:0] wait_cnt;
    ctl_t       ctl;

    // Idle control word: nothing loads, nothing drives the bus, SRAM strobes inactive.
    function automatic ctl_t ctl_idle();
        ctl_t o;
        o        = '0;
        o.mem_oe = 1'b1;
        o.mem_we = 1'b1;
        return o;
    endfunction

    // Next-state logic; wait_done marks the last cycle of a held memory access.
    function automatic state_t next_state(state_t s, logic wait_done, logic run,
                                          logic cont, logic [3:0] op, logic ben);
        state_t n;
        n = s;
        case (s)
            S_HALTED: if (run) n = S_F1;
            S_F1:     n = S_F2;
            S_F2:     if (wait_done) n = S_F3;
            S_F3:     n = S_DEC;
            S_DEC: begin
                case (op)
                    4'b0001: n = S_ADD;
                    4'b0101: n = S_AND;
                    4'b1001: n = S_NOT;
                    4'b0000: n = S_BR;
                    4'b1100: n = S_JMP;
                    4'b0100: n = S_J1;
                    4'b0110: n = S_L1;
                    4'b0111: n = S_S1;
                    4'b1101: n = S_P1;
                    default: n = S_F1;
                endcase
            end
            S_BR:     n = ben ? S_BR_T : S_F1;
            S_J1:     n = S_J2;
            S_L1:     n = S_L2;
            S_L2:     if (wait_done) n = S_L3;
            S_S1:     n = S_S2;
            S_S2:     n = S_S3;
            S_S3:     if (wait_done) n = S_F1;
            S_P1:     if (cont) n = S_P2;
            // Wait for Continue to drop so one press resumes exactly once.
            S_P2:     if (!cont) n = S_F1;
            default:  n = S_F1;
        endcase
        return n;
    endfunction

    // Control word for the state being entered; IR bits are stable once decode starts.
    function automatic ctl_t decode(state_t s, logic ir5, logic ir11);
        ctl_t o;
        o = ctl_idle();
        case (s)
            S_F1: begin
                o.gate_pc = 1'b1;
                o.ld_mar  = 1'b1;
                o.ld_pc   = 1'b1;
            end
            S_F2, S_L2: begin
                o.mem_oe = 1'b0;
                o.ld_mdr = 1'b1;
            end
            S_F3: begin
                o.gate_mdr = 1'b1;
                o.ld_ir    = 1'b1;
            end
            S_DEC: o.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                o.sr1mux   = 1'b1;
                o.gate_alu = 1'b1;
                o.ld_reg   = 1'b1;
                o.ld_cc    = 1'b1;
                o.sr2mux   = (s != S_NOT) ? ir5 : 1'b0;
                o.aluk     = (s == S_ADD) ? 2'b00 : (s == S_AND) ? 2'b01 : 2'b10;
            end
            S_BR_T: begin
                o.addr2mux = 2'b10;
                o.pcmux    = 2'b10;
                o.ld_pc    = 1'b1;
            end
            S_JMP: begin
                o.sr1mux   = 1'b1;
                o.addr1mux = 1'b1;
                o.pcmux    = 2'b10;
                o.ld_pc    = 1'b1;
            end
            // PC already holds PC+1 here, so R7 captures the return address.
            S_J1: begin
                o.gate_pc = 1'b1;
                o.drmux   = 1'b1;
                o.ld_reg  = 1'b1;
            end
            S_J2: begin
                if (ir11) begin
                    o.addr2mux = 2'b11;
                end else begin
                    o.addr1mux = 1'b1;
                    o.sr1mux   = 1'b1;
                end
                o.pcmux = 2'b10;
                o.ld_pc = 1'b1;
            end
            S_L1, S_S1: begin
                o.sr1mux      = 1'b1;
                o.addr1mux    = 1'b1;
                o.addr2mux    = 2'b01;
                o.gate_marmux = 1'b1;
                o.ld_mar      = 1'b1;
            end
            S_L3: begin
                o.gate_mdr = 1'b1;
                o.ld_reg   = 1'b1;
                o.ld_cc    = 1'b1;
            end
            S_S2: begin
                o.aluk     = 2'b11;
                o.gate_alu = 1'b1;
                o.ld_mdr   = 1'b1;
            end
            S_S3: o.mem_we = 1'b0;
            S_P1: o.ld_led = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    // State, memory wait counter and registered control word.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_HALTED;
            wait_cnt <= 3'd0;
            ctl      <= ctl_idle();
        end else begin
            state <= next_state(state, wait_cnt == WAIT_LAST, Run, Continue, Opcode, BEN);
            ctl   <= decode(next_state(state, wait_cnt == WAIT_LAST, Run, Continue, Opcode, BEN),
                            IR_5, IR_11);
            if ((state == S_F2 || state == S_L2 || state == S_S3) && wait_cnt != WAIT_LAST)
                wait_cnt <= wait_cnt + 3'd1;
            else
                wait_cnt <= 3'd0;
        end
    end

    assign LD_MAR     = ctl.ld_mar;
    assign LD_MDR     = ctl.ld_mdr;
    assign LD_IR      = ctl.ld_ir;
    assign LD_BEN     = ctl.ld_ben;
    assign LD_CC      = ctl.ld_cc;
    assign LD_REG     = ctl.ld_reg;
    assign LD_PC      = ctl.ld_pc;
    assign LD_LED     = ctl.ld_led;
    assign GatePC     = ctl.gate_pc;
    assign GateMDR    = ctl.gate_mdr;
    assign GateALU    = ctl.gate_alu;
    assign GateMARMUX = ctl.gate_marmux;
    assign PCMUX      = ctl.pcmux;
    assign DRMUX      = ctl.drmux;
    assign SR1MUX     = ctl.sr1mux;
    assign SR2MUX     = ctl.sr2mux;
    assign ADDR1MUX   = ctl.addr1mux;
    assign ADDR2MUX   = ctl.addr2mux;
    assign ALUK       = ctl.aluk;
    assign Mem_OE     = ctl.mem_oe;
    assign Mem_WE     = ctl.mem_we;

    // Bus contention and SRAM strobe conflict are never allowed.
    a_gate_onehot: assert property (@(posedge Clk) disable iff (!Reset_n)
        $onehot0({GatePC, GateMDR, GateALU, GateMARMUX}));
    a_mem_strobe: assert property (@(posedge Clk) disable iff (!Reset_n)
        !(!Mem_OE && !Mem_WE));

endmodule

// File: tb/tb_slc3_control_fsm.sv
// Directed bench for the SLC-3 control FSM; control words checked against hand-built constants.
module tb_slc3_control_fsm;

    logic       Clk, Reset_n, Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;
    logic [23:0] obs;

    int checks = 0;
    int errors = 0;

    slc3_control_fsm #(.MEM_WAIT(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                  ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

    // Single-bit / field positions within obs
    localparam logic [23:0] B_LD_MAR = 24'h800000, B_LD_MDR = 24'h400000, B_LD_IR  = 24'h200000;
    localparam logic [23:0] B_LD_BEN = 24'h100000, B_LD_CC  = 24'h080000, B_LD_REG = 24'h040000;
    localparam logic [23:0] B_LD_PC  = 24'h020000, B_LD_LED = 24'h010000, B_GPC    = 24'h008000;
    localparam logic [23:0] B_GMDR   = 24'h004000, B_GALU   = 24'h002000, B_GMARMX = 24'h001000;
    localparam logic [23:0] B_PC_AA  = 24'h000800, B_DRMUX  = 24'h000200, B_SR1    = 24'h000100;
    localparam logic [23:0] B_SR2    = 24'h000080, B_A1     = 24'h000040;
    localparam logic [23:0] B_A2_S6  = 24'h000010, B_A2_S9  = 24'h000020, B_A2_S11 = 24'h000030;
    localparam logic [23:0] B_AL_AND = 24'h000004, B_AL_PASS = 24'h00000C;
    localparam logic [23:0] B_OE     = 24'h000002, B_WE     = 24'h000001;

    localparam logic [23:0] IDLE   = B_OE | B_WE;
    localparam logic [23:0] E_F1   = IDLE | B_GPC | B_LD_MAR | B_LD_PC;
    localparam logic [23:0] E_F2   = B_WE | B_LD_MDR;
    localparam logic [23:0] E_F3   = IDLE | B_GMDR | B_LD_IR;
    localparam logic [23:0] E_DEC  = IDLE | B_LD_BEN;
    localparam logic [23:0] E_ADDI = IDLE | B_SR1 | B_SR2 | B_GALU | B_LD_REG | B_LD_CC;
    localparam logic [23:0] E_ANDR = IDLE | B_SR1 | B_GALU | B_LD_REG | B_LD_CC | B_AL_AND;
    localparam logic [23:0] E_BRT  = IDLE | B_A2_S9 | B_PC_AA | B_LD_PC;
    localparam logic [23:0] E_S1   = IDLE | B_SR1 | B_A1 | B_A2_S6 | B_GMARMX | B_LD_MAR;
    localparam logic [23:0] E_S2   = IDLE | B_AL_PASS | B_GALU | B_LD_MDR;
    localparam logic [23:0] E_S3   = B_OE;
    localparam logic [23:0] E_P1   = IDLE | B_LD_LED;
    localparam logic [23:0] E_J1   = IDLE | B_GPC | B_DRMUX | B_LD_REG;
    localparam logic [23:0] E_J2   = IDLE | B_A2_S11 | B_PC_AA | B_LD_PC;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Run = 1'b0; Continue = 1'b0;
        Reset_n = 1'b0;
        #2;
        Reset_n = 1'b1;
        step();
    endtask

    // Run from HALTED up to and including the DEC state (MEM_WAIT=2 fetch).
    task automatic fetch_to_dec();
        Run = 1'b1;
        step();
        Run = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset();
        checks++;
        if (obs !== IDLE) begin errors++; $display("FAIL reset_initial: got %h want %h", obs, IDLE); end
        Reset_n = 1'b1;
        Opcode = 4'b0111;
        fetch_to_dec();
        step(); step(); step();
        checks++;
        if (obs !== E_S3) begin errors++; $display("FAIL reset_reach_s3: got %h want %h", obs, E_S3); end
        Reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== IDLE) begin errors++; $display("FAIL reset_async_abort: got %h want %h", obs, IDLE); end
        step();
        checks++;
        if (obs !== IDLE) begin errors++; $display("FAIL reset_held: got %h want %h", obs, IDLE); end
        #2;
        Reset_n = 1'b1;
        repeat (3) step();
        checks++;
        if (obs !== IDLE) begin errors++; $display("FAIL reset_halt_hold: got %h want %h", obs, IDLE); end
        Run = 1'b1;
        step();
        Run = 1'b0;
        checks++;
        if (obs !== E_F1) begin errors++; $display("FAIL reset_run_f1: got %h want %h", obs, E_F1); end
    endtask

    task automatic test_add();
        logic [23:0] exp_seq [6];
        exp_seq = '{E_F1, E_F2, E_F2, E_F3, E_DEC, E_ADDI};
        do_reset();
        Opcode = 4'b0001; IR_5 = 1'b1;
        Run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            Run = 1'b0;
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++; $display("FAIL add_cycle%0d: got %h want %h", i + 1, obs, exp_seq[i]);
            end
        end
        step();
        checks++;
        if (obs !== E_F1) begin errors++; $display("FAIL add_return_f1: got %h want %h", obs, E_F1); end
        // AND R?,R?,R? (register form) on the following fetch
        Opcode = 4'b0101; IR_5 = 1'b0;
        repeat (5) step();
        checks++;
        if (obs !== E_ANDR) begin errors++; $display("FAIL and_reg: got %h want %h", obs, E_ANDR); end
    endtask

    task automatic test_br();
        do_reset();
        Opcode = 4'b0000; BEN = 1'b1;
        fetch_to_dec();
        step();
        checks++;
        if (obs !== IDLE) begin errors++; $display("FAIL br_state: got %h want %h", obs, IDLE); end
        step();
        checks++;
        if (obs !== E_BRT) begin errors++; $display("FAIL br_taken: got %h want %h", obs, E_BRT); end
        step();
        checks++;
        if (obs !== E_F1) begin errors++; $display("FAIL br_taken_f1: got %h want %h", obs, E_F1); end
        BEN = 1'b0;
        repeat (5) step();
        checks++;
        if (LD_PC !== 1'b0 || obs !== IDLE) begin
            errors++; $display("FAIL br_not_taken_br: got %h want %h", obs, IDLE);
        end
        step();
        checks++;
        if (obs !== E_F1) begin errors++; $display("FAIL br_not_taken_f1: got %h want %h", obs, E_F1); end
    endtask

    task automatic test_str();
        do_reset();
        Opcode = 4'b0111;
        fetch_to_dec();
        step();
        checks++;
        if (obs !== E_S1) begin errors++; $display("FAIL str_s1: got %h want %h", obs, E_S1); end
        step();
        checks++;
        if (obs !== E_S2) begin errors++; $display("FAIL str_s2: got %h want %h", obs, E_S2); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== E_S3) begin errors++; $display("FAIL str_s3_%0d: got %h want %h", i, obs, E_S3); end
        end
        step();
        checks++;
        if (obs !== E_F1) begin errors++; $display("FAIL str_s3_len: got %h want %h", obs, E_F1); end
    endtask

    task automatic test_pause();
        do_reset();
        Opcode = 4'b1101; Continue = 1'b0;
        fetch_to_dec();
        step();
        checks++;
        if (obs !== E_P1) begin errors++; $display("FAIL pause_p1: got %h want %h", obs, E_P1); end
        step();
        checks++;
        if (obs !== E_P1) begin errors++; $display("FAIL pause_p1_hold: got %h want %h", obs, E_P1); end
        Continue = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs !== IDLE) begin errors++; $display("FAIL pause_p2_hold%0d: got %h want %h", i, obs, IDLE); end
        end
        Continue = 1'b0;
        Opcode = 4'b0001;
        step();
        checks++;
        if (obs !== E_F1) begin errors++; $display("FAIL pause_resume_f1: got %h want %h", obs, E_F1); end
        step();
        checks++;
        if (obs !== E_F2) begin errors++; $display("FAIL pause_single_fetch: got %h want %h", obs, E_F2); end
    endtask

    task automatic test_jsr_nop();
        do_reset();
        Opcode = 4'b0100; IR_11 = 1'b1;
        fetch_to_dec();
        step();
        checks++;
        if (obs !== E_J1) begin errors++; $display("FAIL jsr_j1: got %h want %h", obs, E_J1); end
        step();
        checks++;
        if (obs !== E_J2) begin errors++; $display("FAIL jsr_j2: got %h want %h", obs, E_J2); end
        step();
        checks++;
        if (obs !== E_F1) begin errors++; $display("FAIL jsr_f1: got %h want %h", obs, E_F1); end
        Opcode = 4'b1111;
        repeat (4) step();
        checks++;
        if (obs !== E_DEC) begin errors++; $display("FAIL nop_dec: got %h want %h", obs, E_DEC); end
        step();
        checks++;
        if (obs !== E_F1) begin errors++; $display("FAIL nop_f1: got %h want %h", obs, E_F1); end
    endtask

    initial begin
        Reset_n = 1'b0; Run = 1'b0; Continue = 1'b0;
        Opcode = 4'b0000; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
        #12;
        test_reset();
        test_add();
        test_br();
        test_str();
        test_pause();
        test_jsr_nop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
